// File: rtl/piso_arbiter_ctrl.sv
// Round-robin scheduler that feeds one of two requesters' words into the shared
// PISO serialiser, tracks completion and flags a PISO that never reports done.
module piso_arbiter_ctrl #(
    parameter int SIZE_DATA_IN   = 16,
    parameter int SIZE_DATA_OUT  = 2,
    parameter int TIMEOUT_MARGIN = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [1:0]              i_req,
    input  logic [SIZE_DATA_IN-1:0] i_data0,
    input  logic [SIZE_DATA_IN-1:0] i_data1,
    output logic [1:0]              o_gnt,
    output logic                    o_piso_start,
    output logic [SIZE_DATA_IN-1:0] o_piso_data,
    input  logic                    i_piso_done,
    output logic                    o_word_done,
    output logic                    o_word_src,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int SYMS     = SIZE_DATA_IN / SIZE_DATA_OUT;
    localparam int WD_LIMIT = SYMS + 1 + TIMEOUT_MARGIN;
    localparam int WD_W     = $clog2(SYMS + 2 + TIMEOUT_MARGIN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    generate
        if ((SIZE_DATA_IN % SIZE_DATA_OUT) != 0) begin : g_bad_width
            $error("SIZE_DATA_IN must be a multiple of SIZE_DATA_OUT");
        end
    endgenerate

    logic [1:0]              state_q, state_d;
    logic [1:0]              gnt_q, gnt_d;
    logic                    start_q, start_d;
    logic [SIZE_DATA_IN-1:0] data_q, data_d;
    logic                    done_q, done_d;
    logic                    src_q, src_d;
    logic                    err_q, err_d;
    logic                    prio_q, prio_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [WD_W-1:0]         wd_inc;
    logic                    win;

    assign wd_inc = wd_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = 2'b00;
        start_d = start_q;
        data_d  = data_q;
        done_d  = 1'b0;
        src_d   = src_q;
        err_d   = err_q;
        prio_d  = prio_q;
        wd_d    = wd_q;
        win     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_d = 1'b0;
                if (i_en && (i_req != 2'b00)) begin
                    // Pointer holder wins a tie; otherwise whoever is asking.
                    win     = i_req[prio_q] ? prio_q : ~prio_q;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    data_d  = win ? i_data1 : i_data0;
                    src_d   = win;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                start_d = 1'b1;
                wd_d    = wd_inc;
                // Done wins over a watchdog expiry landing on the same cycle.
                if (i_piso_done) begin
                    done_d  = 1'b1;
                    prio_d  = ~src_q;
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (wd_inc == WD_W'(WD_LIMIT)) begin
                    err_d   = 1'b1;
                    prio_d  = ~src_q;
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            start_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            done_q  <= done_d;
            src_q   <= src_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
            wd_q    <= wd_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_piso_start = start_q;
    assign o_piso_data  = data_q;
    assign o_word_done  = done_q;
    assign o_word_src   = src_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_piso_arbiter_ctrl.sv
// Transaction-level bench for piso_arbiter_ctrl: a round-robin model predicts the
// winner of each word, and a PISO model answers done after a chosen number of cycles.
module tb_piso_arbiter_ctrl;

    localparam int SYMS  = 16 / 2;
    localparam int LIMIT = SYMS + 1 + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic [1:0]  i_req;
    logic [15:0] i_data0, i_data1;
    logic [1:0]  o_gnt;
    logic        o_piso_start;
    logic [15:0] o_piso_data;
    logic        i_piso_done;
    logic        o_word_done, o_word_src, o_busy, o_err;

    int vectors = 0;
    int miscompares = 0;
    int m_prio = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    piso_arbiter_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (i_en),
        .i_req       (i_req),
        .i_data0     (i_data0),
        .i_data1     (i_data1),
        .o_gnt       (o_gnt),
        .o_piso_start(o_piso_start),
        .o_piso_data (o_piso_data),
        .i_piso_done (i_piso_done),
        .o_word_done (o_word_done),
        .o_word_src  (o_word_src),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word: request, grant check, PISO model answering done on start-cycle done_at
    // (values beyond the watchdog limit mean the PISO never answers).
    task automatic serve(input logic [1:0] req, input logic [15:0] d0, input logic [15:0] d1,
                         input int done_at, input bit hold, input bit drop_en);
        int  win;
        int  n;
        bit  found;
        bit  exp_done;
        int  exp_len;
        win = req[m_prio] ? m_prio : 1 - m_prio;
        i_req = req; i_data0 = d0; i_data1 = d1; i_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk); #1;
            if (o_gnt != 2'b00) found = 1'b1;
        end
        chk("grant_seen", 32'(found), 32'd1);
        if (!found) return;
        chk("gnt", 32'(o_gnt), (win == 1) ? 32'h2 : 32'h1);
        chk("piso_data", 32'(o_piso_data), (win == 1) ? 32'(d1) : 32'(d0));
        chk("word_src", 32'(o_word_src), 32'(win));
        chk("start_at_grant", 32'(o_piso_start), 32'd0);
        if (!hold) i_req = 2'b00;
        if (drop_en) i_en = 1'b0;
        @(posedge clk); #1;
        chk("start_after_grant", 32'(o_piso_start), 32'd1);
        chk("gnt_pulse", 32'(o_gnt), 32'd0);
        n = 1;
        i_piso_done = (n == done_at);
        while (n <= 20) begin
            @(posedge clk); #1;
            i_piso_done = 1'b0;
            if (!o_piso_start) break;
            chk("no_gnt_busy", 32'(o_gnt), 32'd0);
            n++;
            i_piso_done = (n == done_at);
        end
        exp_done = (done_at >= 1) && (done_at <= LIMIT);
        exp_len  = exp_done ? done_at : LIMIT;
        if (!exp_done) m_err = 1'b1;
        chk("start_len", 32'(n), 32'(exp_len));
        chk("word_done", 32'(o_word_done), 32'(exp_done));
        chk("err", 32'(o_err), 32'(m_err));
        chk("busy_idle", 32'(o_busy), 32'd0);
        $display("word: req=%b win=%0d done_at=%0d start_len=%0d word_done=%0b err=%0b",
                 req, win, done_at, n, o_word_done, o_err);
        m_prio = 1 - win;
    endtask

    initial begin
        rst_n = 1'b0; i_en = 1'b0; i_req = 2'b00; i_data0 = '0; i_data1 = '0; i_piso_done = 1'b0;
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_start", 32'(o_piso_start), 32'd0);
        chk("rst_data", 32'(o_piso_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        #24 rst_n = 1'b1;

        // Single requester, PISO answers after 8 symbols (9th start cycle).
        serve(2'b01, 16'hAAAA, 16'h0000, SYMS + 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("word_done_pulse", 32'(o_word_done), 32'd0);

        // Reset in the middle of a word; pointer now favours 1 and must return to 0.
        i_req = 2'b01; i_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_shift_busy", 32'(o_busy), 32'd1);
        i_req = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(o_piso_start), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_data", 32'(o_piso_data), 32'd0);
        chk("arst_src", 32'(o_word_src), 32'd0);
        #19 rst_n = 1'b1;
        m_prio = 0; m_err = 1'b0;
        serve(2'b11, 16'h1234, 16'hBEEF, SYMS + 1, 1'b0, 1'b0);

        // Continuous contention: strict alternation.
        for (int k = 0; k < 4; k++) serve(2'b11, 16'h1234, 16'hBEEF, SYMS + 1, 1'b1, 1'b0);
        i_req = 2'b00;

        // Done on the watchdog's last cycle, then a silent PISO, then recovery.
        serve(2'b10, 16'h0001, 16'h0002, LIMIT, 1'b0, 1'b0);
        serve(2'b10, 16'h0003, 16'h0004, 0, 1'b0, 1'b0);
        serve(2'b01, 16'h0005, 16'h0006, 3, 1'b0, 1'b0);

        // Enable dropped mid-word: no new grant until re-enabled.
        serve(2'b11, 16'h5555, 16'h6666, 5, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("en_low_gnt", 32'(o_gnt), 32'd0);
            chk("en_low_busy", 32'(o_busy), 32'd0);
        end
        serve(2'b11, 16'h5555, 16'h6666, 5, 1'b0, 1'b0);

        // Stray done while idle.
        i_req = 2'b00; i_piso_done = 1'b1;
        @(posedge clk); #1;
        i_piso_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("idle_done_busy", 32'(o_busy), 32'd0);
            chk("idle_done_wd", 32'(o_word_done), 32'd0);
            @(posedge clk); #1;
        end

        // Randomised words, including some timeouts.
        for (int k = 0; k < 30; k++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            serve(r, 16'($urandom), 16'($urandom), int'($urandom_range(1, LIMIT + 2)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
